// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_e    : converter FSM states
//   int_digits : decimal digits needed to hold any DATA_W-bit value
//   BCD_W      : bits per BCD digit
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  localparam int unsigned BCD_W = 4;

  // ceil(w/3): every 3 binary bits need at most one more decimal digit.
  function automatic int unsigned int_digits(input int unsigned w);
    return (w + 2) / 3;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble correction for one BCD digit.
//   digit_i : scratch digit before the shift (0-9)
//   digit_o : digit_i + 3 when digit_i >= 5, else digit_i
module bcd_add3_digit
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_W'(5)) begin
      digit_o = digit_i + BCD_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   start_i : conversion request, sampled only while idle
//   data_i  : binary value, captured when start_i is accepted
//   busy_o  : high from the cycle after accept through the done cycle
//   done_o  : one-cycle pulse; bcd_o/ovf_o are valid from this cycle on
//   bcd_o   : packed BCD, digit 0 (units) in [3:0]
//   ovf_o   : value needed more than DIGITS decimal digits
//   blank_o : leading-zero blank flags, present only with BIN2BCD_LZB_EN defined
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIGITS = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [DATA_W-1:0]       data_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [BCD_W*DIGITS-1:0] bcd_o,
`ifdef BIN2BCD_LZB_EN
  output logic [DIGITS-1:0]       blank_o,
`endif
  output logic                    ovf_o
);

  localparam int unsigned IntDigits = int_digits(DATA_W);
  // Scratch is never narrower than the output so the bcd slice is always in range.
  localparam int unsigned ScrDigits = (IntDigits > DIGITS) ? IntDigits : DIGITS;
  localparam int unsigned ScrW      = ScrDigits * BCD_W;
  localparam int unsigned CntW      = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  state_e                    state_q;
  logic [DATA_W-1:0]         shift_q;
  logic [ScrW-1:0]           scratch_q;
  logic [CntW-1:0]           cnt_q;
  logic                      busy_q;
  logic                      done_q;
  logic [BCD_W*DIGITS-1:0]   bcd_q;
  logic                      ovf_q;

  logic [ScrW-1:0]           scr_adj;
  logic [ScrW+DATA_W-1:0]    cat_shl;
  logic [ScrW-1:0]           scr_d;
  logic [DATA_W-1:0]         shift_d;
  logic [BCD_W*DIGITS-1:0]   bcd_d;
  logic                      ovf_d;

  for (genvar g = 0; g < ScrDigits; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i (scratch_q[g*BCD_W +: BCD_W]),
      .digit_o (scr_adj[g*BCD_W +: BCD_W])
    );
  end

  // Add-3 first, then shift {scratch, shift} left by one.
  always_comb begin
    cat_shl = {scr_adj, shift_q} << 1;
    scr_d   = cat_shl[ScrW+DATA_W-1:DATA_W];
    shift_d = cat_shl[DATA_W-1:0];
    bcd_d   = scr_d[BCD_W*DIGITS-1:0];
    ovf_d   = 1'b0;
    for (int i = DIGITS; i < ScrDigits; i++) begin
      if (scr_d[i*BCD_W +: BCD_W] != '0) begin
        ovf_d = 1'b1;
      end
    end
  end

`ifdef BIN2BCD_LZB_EN
  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_d;
  logic              zero_run;

  // A digit blanks when it and every digit above it are zero; units never blanks.
  always_comb begin
    blank_d  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (bcd_d[i*BCD_W +: BCD_W] == '0);
      blank_d[i] = zero_run;
    end
  end

  assign blank_o = blank_q;
`endif

  // Results are registered on the final shift edge so they are already valid
  // in the DONE cycle alongside the done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
`ifdef BIN2BCD_LZB_EN
      blank_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            shift_q   <= data_i;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= StConv;
          end
        end
        StConv: begin
          scratch_q <= scr_d;
          shift_q   <= shift_d;
          cnt_q     <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
`ifdef BIN2BCD_LZB_EN
            blank_q <= blank_d;
`endif
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (DATA_W=32, DIGITS=8).
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] data;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        ovf;
`ifdef BIN2BCD_LZB_EN
  logic [7:0]  blank;
`endif

  int checks   = 0;
  int failures = 0;

  bin2bcd_seq #(
    .DATA_W (32),
    .DIGITS (8)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .data_i  (data),
    .busy_o  (busy),
    .done_o  (done),
    .bcd_o   (bcd),
`ifdef BIN2BCD_LZB_EN
    .blank_o (blank),
`endif
    .ovf_o   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts a conversion and observes 45 cycles after the accept edge.
  // Cycle c=1 is the cycle right after the accept edge.
  task automatic run_conv(input logic [31:0] d, input int inj_cycle, input logic [31:0] inj_data,
                          input int rst_cycle, output logic [31:0] bcd_at_done,
                          output logic ovf_at_done, output int busy_n, output int done_n,
                          output int done_at);
    busy_n      = 0;
    done_n      = 0;
    done_at     = -1;
    bcd_at_done = 'x;
    ovf_at_done = 1'bx;
    @(negedge clk);
    start = 1'b1;
    data  = d;
    @(posedge clk);
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        done_n++;
        if (done_at < 0) begin
          done_at     = c;
          bcd_at_done = bcd;
          ovf_at_done = ovf;
        end
      end
      if (c == 1) start = 1'b0;
      if (c == 2) data = 32'hdead_beef;
      if (c == inj_cycle) begin
        start = 1'b1;
        data  = inj_data;
      end
      if (c == inj_cycle + 1) start = 1'b0;
      if (c == rst_cycle) begin
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_done", 64'(done), 64'(0));
        check("rst_mid_bcd", 64'(bcd), 64'(0));
        check("rst_mid_ovf", 64'(ovf), 64'(0));
      end
      if (c == rst_cycle + 1) rst = 1'b0;
    end
  endtask

  vec_t        vecs[10];
  logic [31:0] r_bcd;
  logic        r_ovf;
  int          r_busy;
  int          r_done;
  int          r_at;
  int          d_first;
  int          d_second;
  int          d_cnt;

  initial begin
    vecs[0] = '{32'd0,         32'h0000_0000, 1'b0};
    vecs[1] = '{32'd12345678,  32'h1234_5678, 1'b0};
    vecs[2] = '{32'd99999999,  32'h9999_9999, 1'b0};
    vecs[3] = '{32'd100000000, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'h9496_7295, 1'b1};
    vecs[5] = '{32'd5,         32'h0000_0005, 1'b0};
    vecs[6] = '{32'd9,         32'h0000_0009, 1'b0};
    vecs[7] = '{32'd10,        32'h0000_0010, 1'b0};
    vecs[8] = '{32'd305,       32'h0000_0305, 1'b0};
    vecs[9] = '{32'd4096,      32'h0000_4096, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    data  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_bcd", 64'(bcd), 64'(0));
    check("reset_ovf", 64'(ovf), 64'(0));
`ifdef BIN2BCD_LZB_EN
    check("reset_blank", 64'(blank), 64'(0));
`endif
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].data, -10, 32'd0, -10, r_bcd, r_ovf, r_busy, r_done, r_at);
      check($sformatf("vec%0d_bcd", i), 64'(r_bcd), 64'(vecs[i].bcd));
      check($sformatf("vec%0d_ovf", i), 64'(r_ovf), 64'(vecs[i].ovf));
      check($sformatf("vec%0d_done_at", i), 64'(r_at), 64'(33));
      check($sformatf("vec%0d_done_n", i), 64'(r_done), 64'(1));
      check($sformatf("vec%0d_busy_n", i), 64'(r_busy), 64'(33));
      check($sformatf("vec%0d_hold", i), 64'(bcd), 64'(vecs[i].bcd));
    end

    // start_i pulsed mid-conversion must be ignored.
    run_conv(32'd1234, 10, 32'd5, -10, r_bcd, r_ovf, r_busy, r_done, r_at);
    check("ign_bcd", 64'(r_bcd), 64'(32'h1234));
    check("ign_done_n", 64'(r_done), 64'(1));
    check("ign_done_at", 64'(r_at), 64'(33));
    check("ign_hold", 64'(bcd), 64'(32'h1234));

    // Reset mid-conversion aborts with no done pulse.
    run_conv(32'd5678, -10, 32'd0, 15, r_bcd, r_ovf, r_busy, r_done, r_at);
    check("rst_done_n", 64'(r_done), 64'(0));
    check("rst_bcd_after", 64'(bcd), 64'(0));
    check("rst_busy_after", 64'(busy), 64'(0));

    run_conv(32'd305, -10, 32'd0, -10, r_bcd, r_ovf, r_busy, r_done, r_at);
    check("post_rst_bcd", 64'(r_bcd), 64'(32'h305));
    check("post_rst_done_at", 64'(r_at), 64'(33));
`ifdef BIN2BCD_LZB_EN
    check("blank_305", 64'(blank), 64'(8'b1111_1000));
`endif

    // start_i held high: conversions every DATA_W+2 cycles.
    d_first  = -1;
    d_second = -1;
    d_cnt    = 0;
    @(negedge clk);
    start = 1'b1;
    data  = 32'd42;
    @(posedge clk);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        d_cnt++;
        if (d_first < 0) d_first = c;
        else if (d_second < 0) d_second = c;
      end
      if (c == 60) start = 1'b0;
    end
    check("b2b_done_n", 64'(d_cnt), 64'(2));
    check("b2b_first", 64'(d_first), 64'(33));
    check("b2b_second", 64'(d_second), 64'(67));
    check("b2b_bcd", 64'(bcd), 64'(32'h42));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
